devtbl_scan: RTL and testbench
==============================

DEVTBL_SCAN -- requirements
Module: devtbl_scan

Interface
REQ-001 Parameters: ARCHBITSZ, default 16, data and address width in bits; DEVTBLADDR, default 1024/(ARCHBITSZ/8), device-table word address; MAXDEVCNT, default 8, maximum entries scanned; TIMEOUT, default 255, ack wait limit in cycles.
REQ-002 Ports, clock and reset first (ADDRBITSZ = ARCHBITSZ-clog2(ARCHBITSZ/8)):
- clk_i, in, 1, single clock.
- rst_i, in, 1, reset, asynchronous and active-high.
- start_i, in, 1, begin scan; sampled only in IDLE.
- tgtid_i, in, ARCHBITSZ, DevId to locate.
- wb_cyc_o, out, 1, bus cycle.
- wb_stb_o, out, 1, request strobe.
- wb_we_o, out, 1, write when 1.
- wb_addr_o, out, ADDRBITSZ, word address.
- wb_sel_o, out, ARCHBITSZ/8, byte lanes; always all-ones.
- wb_dat_o, out, ARCHBITSZ, write data.
- wb_bsy_i, in, 1, responder busy.
- wb_ack_i, in, 1, transfer done.
- wb_dat_i, in, ARCHBITSZ, read data.
- busy_o, out, 1, scan in progress.
- done_o, out, 1, one-cycle completion pulse.
- err_o, out, 1, sticky timeout flag; cleared by next start.
- found_o, out, 1, tgtid_i matched.
- mbase_o, out, ARCHBITSZ, byte base of matched device.
- mmapsz_o, out, ARCHBITSZ, mapsz of matched device.
- museirq_o, out, 1, useirq of matched device.
- midx_o, out, ARCHBITSZ, index of matched device.
- devcnt_o, out, ARCHBITSZ, entries scanned.
- socver_o, out, ARCHBITSZ, SoC version (info option only).
- socid_o, out, ARCHBITSZ, SoC id (info option only).

Function
REQ-003 Bus transfer: drive cyc=stb=1 with address/we/data; request accepted on the first edge where wb_bsy_i==0; stb deasserts the following cycle; cyc stays high until wb_ack_i==1; wb_dat_i is captured on the ack cycle; one transfer outstanding at a time.
REQ-004 States: IDLE, SELDEVS, RDID, RDSZ, DONE; with REQ-013 enabled also SELINFO, RDVER, RDSOCID.
REQ-005 IDLE with start_i=1: clear found/err/devcnt, base accumulator=0, idx=0, busy_o=1; go to SELINFO (option enabled) or SELDEVS.
REQ-006 SELDEVS: write value 5 to DEVTBLADDR; go to RDID on ack.
REQ-007 RDID: read address DEVTBLADDR+2*idx and latch id; RDSZ: read DEVTBLADDR+2*idx+1; mapsz = data with bit0 cleared, useirq = data bit0.
REQ-008 After RDSZ: if id==0 and mapsz==0, go to DONE without counting the entry; else devcnt+=1; if id==tgtid_i and found==0, latch found=1 and mbase/mmapsz/museirq/midx (first match wins); base+=mapsz modulo 2^ARCHBITSZ; idx+=1; if idx==MAXDEVCNT go to DONE, else go to RDID.
REQ-009 DONE: done_o=1 for exactly one cycle, busy_o=0, return to IDLE; outputs hold until next start.
REQ-010 Timeout: counter resets at each request and counts while awaiting ack; reaching TIMEOUT sets err_o=1, drops cyc/stb, goes to DONE; results hold partial values.
REQ-011 start_i while busy_o=1 is ignored; ack_i arriving while no transfer is outstanding is ignored.

Reset
REQ-012 rst_i asserted at any time, including mid-transfer, forces state IDLE and all outputs and counters to 0 asynchronously; the bus is released within the same cycle.

Configuration
REQ-013 Macro DEVTBLSCAN_INFO_EN: when defined, the scan first writes 4 (RDSELINFO) to DEVTBLADDR, reads word 0 into socver_o and word 4 into socid_o, then continues at SELDEVS. When undefined, SELINFO, RDVER and RDSOCID are absent and socver_o=socid_o=0.

Verification
REQ-014 Table ids {7,5,1,0}, mapsz {1024,2048,4096,0}, tgtid_i=1 -> found=1, mbase=0xC00, midx=2, devcnt=3, done pulse once.
REQ-015 tgtid_i=9 not present, MAXDEVCNT=8, all ids nonzero -> found=0, devcnt=8, exactly 1+16 bus transfers.
REQ-016 Responder holds bsy=1 for 3 cycles, ack 2 cycles after accept -> stb held for 4 cycles, data captured on the ack cycle.
REQ-017 No ack, TIMEOUT=255 -> err_o=1 after 255 wait cycles, cyc=0, done pulse.
REQ-018 rst_i asserted during RDSZ -> all outputs 0 immediately; a new start then rescans from idx 0.
REQ-019 With DEVTBLSCAN_INFO_EN defined, version 0x0102 and SOCID 3 -> socver_o=0x0102, socid_o=3, first write data=4.

Source files
------------

// File: rtl/devtbl_scan.sv
// Device-table scanner: walks the device table over a Wishbone-style bus and reports the first entry whose DevId matches tgtid_i.
// Define DEVTBLSCAN_INFO_EN to also read the SoC version and id before the scan.
module devtbl_scan #(
    parameter int ARCHBITSZ  = 16,
    parameter int DEVTBLADDR = 1024/(ARCHBITSZ/8),
    parameter int MAXDEVCNT  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      start_i,
    input  logic [ARCHBITSZ-1:0]                      tgtid_i,
    output logic                                      wb_cyc_o,
    output logic                                      wb_stb_o,
    output logic                                      wb_we_o,
    output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]  wb_addr_o,
    output logic [ARCHBITSZ/8-1:0]                    wb_sel_o,
    output logic [ARCHBITSZ-1:0]                      wb_dat_o,
    input  logic                                      wb_bsy_i,
    input  logic                                      wb_ack_i,
    input  logic [ARCHBITSZ-1:0]                      wb_dat_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      err_o,
    output logic                                      found_o,
    output logic [ARCHBITSZ-1:0]                      mbase_o,
    output logic [ARCHBITSZ-1:0]                      mmapsz_o,
    output logic                                      museirq_o,
    output logic [ARCHBITSZ-1:0]                      midx_o,
    output logic [ARCHBITSZ-1:0]                      devcnt_o,
    output logic [ARCHBITSZ-1:0]                      socver_o,
    output logic [ARCHBITSZ-1:0]                      socid_o
);

    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8);
    localparam int TMOBITS   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef logic [ARCHBITSZ-1:0] word_t;

`ifdef DEVTBLSCAN_INFO_EN
    typedef enum logic [2:0] {IDLE, SELINFO, RDVER, RDSOCID, SELDEVS, RDID, RDSZ, DONE} state_t;
    localparam state_t FIRST = SELINFO;
    word_t socver, socid;
`else
    typedef enum logic [2:0] {IDLE, SELDEVS, RDID, RDSZ, DONE} state_t;
    localparam state_t FIRST = SELDEVS;
`endif

    state_t             state, state_nx;
    logic               phase;          // 0: strobing request, 1: accepted, awaiting ack
    logic [TMOBITS-1:0] tmo;
    word_t              id, base, idx;
    logic               found, err, museirq;
    word_t              devcnt, mbase, mmapsz, midx;

    logic  cyc, we, ack_ok, tmo_hit, last, term;
    word_t wdata, addr, mapsz;

    assign mapsz   = {wb_dat_i[ARCHBITSZ-1:1], 1'b0};
    assign last    = (idx == word_t'(MAXDEVCNT - 1));
    assign term    = (id == '0) && (mapsz == '0);
    // An ack during the accept cycle itself is honoured, so zero-wait responders work.
    assign ack_ok  = cyc && wb_ack_i && (phase || !wb_bsy_i);
    assign tmo_hit = cyc && !ack_ok && (tmo == TMOBITS'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        cyc      = 1'b0;
        we       = 1'b0;
        wdata    = '0;
        addr     = word_t'(DEVTBLADDR);
        case (state)
            SELDEVS: begin cyc = 1'b1; we = 1'b1; wdata = word_t'(5); end
            RDID:    begin cyc = 1'b1; addr = word_t'(DEVTBLADDR) + (idx << 1); end
            RDSZ:    begin cyc = 1'b1; addr = word_t'(DEVTBLADDR) + (idx << 1) + word_t'(1); end
`ifdef DEVTBLSCAN_INFO_EN
            SELINFO: begin cyc = 1'b1; we = 1'b1; wdata = word_t'(4); end
            RDVER:   begin cyc = 1'b1; end
            RDSOCID: begin cyc = 1'b1; addr = word_t'(DEVTBLADDR) + word_t'(4); end
`endif
            default: ;
        endcase

        case (state)
            IDLE: if (start_i) state_nx = FIRST;
            DONE: state_nx = IDLE;
            default: begin
                if (!cyc) begin
                    state_nx = IDLE;
                end else if (ack_ok) begin
                    case (state)
                        SELDEVS: state_nx = RDID;
                        RDID:    state_nx = RDSZ;
                        RDSZ:    state_nx = (term || last) ? DONE : RDID;
`ifdef DEVTBLSCAN_INFO_EN
                        SELINFO: state_nx = RDVER;
                        RDVER:   state_nx = RDSOCID;
                        RDSOCID: state_nx = SELDEVS;
`endif
                        default: state_nx = IDLE;
                    endcase
                end else if (tmo_hit) begin
                    state_nx = DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            phase   <= 1'b0;
            tmo     <= '0;
            id      <= '0;
            base    <= '0;
            idx     <= '0;
            found   <= 1'b0;
            err     <= 1'b0;
            museirq <= 1'b0;
            devcnt  <= '0;
            mbase   <= '0;
            mmapsz  <= '0;
            midx    <= '0;
`ifdef DEVTBLSCAN_INFO_EN
            socver  <= '0;
            socid   <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                phase <= 1'b0;
                tmo   <= '0;
            end else if (cyc) begin
                if (!phase && !wb_bsy_i) phase <= 1'b1;
                tmo <= tmo + 1'b1;
            end
            if (tmo_hit) err <= 1'b1;

            case (state)
                IDLE: if (start_i) begin
                    found   <= 1'b0;
                    err     <= 1'b0;
                    devcnt  <= '0;
                    base    <= '0;
                    idx     <= '0;
                    mbase   <= '0;
                    mmapsz  <= '0;
                    museirq <= 1'b0;
                    midx    <= '0;
`ifdef DEVTBLSCAN_INFO_EN
                    socver  <= '0;
                    socid   <= '0;
`endif
                end
                RDID: if (ack_ok) id <= wb_dat_i;
                RDSZ: if (ack_ok && !term) begin
                    devcnt <= devcnt + 1'b1;
                    if (id == tgtid_i && !found) begin
                        found   <= 1'b1;
                        mbase   <= base;
                        mmapsz  <= mapsz;
                        museirq <= wb_dat_i[0];
                        midx    <= idx;
                    end
                    base <= base + mapsz;
                    idx  <= idx + 1'b1;
                end
`ifdef DEVTBLSCAN_INFO_EN
                RDVER:   if (ack_ok) socver <= wb_dat_i;
                RDSOCID: if (ack_ok) socid <= wb_dat_i;
`endif
                default: ;
            endcase
        end
    end

    assign wb_cyc_o  = cyc;
    assign wb_stb_o  = cyc && !phase;
    assign wb_we_o   = we;
    assign wb_addr_o = addr[ADDRBITSZ-1:0];
    assign wb_sel_o  = '1;
    assign wb_dat_o  = wdata;
    assign busy_o    = (state != IDLE) && (state != DONE);
    assign done_o    = (state == DONE);
    assign err_o     = err;
    assign found_o   = found;
    assign mbase_o   = mbase;
    assign mmapsz_o  = mmapsz;
    assign museirq_o = museirq;
    assign midx_o    = midx;
    assign devcnt_o  = devcnt;
`ifdef DEVTBLSCAN_INFO_EN
    assign socver_o  = socver;
    assign socid_o   = socid;
`else
    assign socver_o  = '0;
    assign socid_o   = '0;
`endif

endmodule

// File: tb/tb_devtbl_scan.sv
// Self-checking bench for devtbl_scan: table-driven scans against a behavioural bus responder,
// plus timeout and mid-scan reset sequences. Honours DEVTBLSCAN_INFO_EN when defined.
module tb_devtbl_scan;

    localparam int W    = 16;
    localparam int AW   = W - $clog2(W/8);
    localparam int DTA  = 512;
    localparam int MAXN = 8;
    localparam int TMO  = 255;
`ifdef DEVTBLSCAN_INFO_EN
    localparam int       PRE   = 4;
    localparam int       EXP_W = 4;
    localparam [W-1:0]   EXP_V = 16'h0102;
    localparam [W-1:0]   EXP_S = 16'h0003;
`else
    localparam int       PRE   = 1;
    localparam int       EXP_W = 5;
    localparam [W-1:0]   EXP_V = 16'h0000;
    localparam [W-1:0]   EXP_S = 16'h0000;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, force_ack = 1'b0;
    logic [W-1:0] tgtid = '0;
    logic cyc, stb, we;
    logic [AW-1:0] addr;
    logic [W/8-1:0] sel;
    logic [W-1:0] wdat;
    logic bsy = 1'b0, ack = 1'b0;
    logic [W-1:0] rdat = '0;
    logic busy_o, done_o, err_o, found_o, museirq_o;
    logic [W-1:0] mbase_o, mmapsz_o, midx_o, devcnt_o, socver_o, socid_o;

    always #5 clk = ~clk;

    devtbl_scan #(.ARCHBITSZ(W), .DEVTBLADDR(DTA), .MAXDEVCNT(MAXN), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tgtid_i(tgtid),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr), .wb_sel_o(sel),
        .wb_dat_o(wdat), .wb_bsy_i(bsy), .wb_ack_i(ack | force_ack), .wb_dat_i(rdat),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .found_o(found_o),
        .mbase_o(mbase_o), .mmapsz_o(mmapsz_o), .museirq_o(museirq_o), .midx_o(midx_o),
        .devcnt_o(devcnt_o), .socver_o(socver_o), .socid_o(socid_o)
    );

    typedef logic [W-1:0] tbl_t [MAXN];

    typedef struct {
        logic [W-1:0] tgt;
        tbl_t ids;
        tbl_t szs;
        int bsy_n;
        int ack_n;
        logic found;
        logic museirq;
        logic [W-1:0] mbase, mmapsz, midx, devcnt;
        int xfers;
    } vec_t;

    typedef struct packed {
        logic err, found, museirq;
        logic [W-1:0] mbase, mmapsz, midx, devcnt, socver, socid;
    } res_t;

    // Responder configuration (written by the main process) and logs (written by the responder)
    tbl_t t_id, t_sz;
    int bsy_cycles = 0, ack_delay = 1;
    bit no_ack = 1'b0;
    logic [AW-1:0] alog [$];
    logic [W-1:0]  wlog [$];
    int stblog [$];
    int stb_viol = 0;

    res_t sb [$];
    vec_t vt [8];
    int n_chk = 0, n_fail = 0;

    function automatic logic [W-1:0] rd_word(input logic [AW-1:0] a, input logic [W-1:0] s);
        int off;
        off = int'(a) - DTA;
        if (s == 16'd4) return (off == 0) ? 16'h0102 : (off == 4) ? 16'h0003 : 16'h0000;
        if (off < 0 || off >= 2*MAXN) return 16'h0000;
        return off[0] ? t_sz[off/2] : t_id[off/2];
    endfunction

    initial begin : responder
        int rs, wb_n, wa_n, stb_n;
        logic [AW-1:0] a;
        logic [W-1:0] selv;
        rs = 0; wb_n = 0; wa_n = 0; stb_n = 0; a = '0; selv = '0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            rdat = 16'hDEAD;
            if (rst || !cyc) begin
                rs = 0; wb_n = 0; stb_n = 0; bsy = 1'b0;
            end else if (rs == 1) begin
                bsy = 1'b0;
                if (stb) stb_viol++;
                wa_n++;
                if (!no_ack && wa_n >= ack_delay) begin
                    ack = 1'b1;
                    rdat = rd_word(a, selv);
                    rs = 0; wb_n = 0; stb_n = 0;
                end
            end else if (stb) begin
                stb_n++;
                if (wb_n < bsy_cycles) begin
                    bsy = 1'b1;
                    wb_n++;
                end else begin
                    bsy = 1'b0;
                    rs = 1; wa_n = 0; a = addr;
                    alog.push_back(addr);
                    stblog.push_back(stb_n);
                    if (we) begin
                        wlog.push_back(wdat);
                        selv = wdat;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic set_vec(input int i, input logic [W-1:0] tgt, input tbl_t ids, input tbl_t szs,
                           input int bn, input int an, input logic f, input logic irq,
                           input logic [W-1:0] mb, input logic [W-1:0] ms, input logic [W-1:0] mi,
                           input logic [W-1:0] dc, input int nx);
        vt[i].tgt = tgt; vt[i].ids = ids; vt[i].szs = szs;
        vt[i].bsy_n = bn; vt[i].ack_n = an;
        vt[i].found = f; vt[i].museirq = irq;
        vt[i].mbase = mb; vt[i].mmapsz = ms; vt[i].midx = mi; vt[i].devcnt = dc;
        vt[i].xfers = nx;
    endtask

    task automatic run_scan(input logic [W-1:0] tgt, input res_t e, input int exp_x, input int exp_stb,
                            input bit poke, output int ncyc);
        int base_x, base_w, viol0;
        bit seen;
        res_t r;
        sb.push_back(e);
        base_x = alog.size(); base_w = wlog.size(); viol0 = stb_viol;
        @(negedge clk); tgtid = tgt; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_during_scan", 32'(busy_o), 32'd1);
        ncyc = cyc ? 1 : 0;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            start = (poke && c == 8) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (cyc) ncyc++;
            if (done_o) begin
                seen = 1'b1;
                r = sb.pop_front();
                chk("err",     32'(err_o),     32'(r.err));
                chk("found",   32'(found_o),   32'(r.found));
                chk("museirq", 32'(museirq_o), 32'(r.museirq));
                chk("mbase",   32'(mbase_o),   32'(r.mbase));
                chk("mmapsz",  32'(mmapsz_o),  32'(r.mmapsz));
                chk("midx",    32'(midx_o),    32'(r.midx));
                chk("devcnt",  32'(devcnt_o),  32'(r.devcnt));
                chk("socver",  32'(socver_o),  32'(r.socver));
                chk("socid",   32'(socid_o),   32'(r.socid));
                chk("cyc_at_done", 32'(cyc), 32'd0);
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'({done_o, busy_o}), 32'd0);
        chk("xfer_count", 32'(alog.size() - base_x), 32'(exp_x));
        chk("first_wdata", 32'((wlog.size() > base_w) ? wlog[base_w] : 16'hFFFF), 32'(EXP_W));
        chk("first_stb_len", 32'((stblog.size() > base_x) ? stblog[base_x] : -1), 32'(exp_stb));
        if (exp_x > PRE)
            chk("first_rdid_addr", 32'(alog[base_x + PRE]), 32'(DTA));
        chk("stb_after_accept", 32'(stb_viol - viol0), 32'd0);
    endtask

    initial begin : main
        int ncyc;
        bit hit;
        res_t e;

        set_vec(0, 16'd1,  '{16'd7, 16'd5, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'h0400, 16'h0800, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                0, 1, 1'b1, 1'b0, 16'h0C00, 16'h1000, 16'd2, 16'd3, 9);
        set_vec(1, 16'd9,  '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd10},
                '{16'h100, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100},
                1, 1, 1'b0, 1'b0, 16'h0, 16'h0, 16'd0, 16'd8, 17);
        set_vec(2, 16'd3,  '{16'd3, 16'd4, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'h0201, 16'h0041, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                3, 2, 1'b1, 1'b1, 16'h0, 16'h0200, 16'd0, 16'd3, 9);
        set_vec(3, 16'd6,  '{16'd0, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'h0080, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                2, 3, 1'b1, 1'b0, 16'h0080, 16'h1000, 16'd1, 16'd2, 7);
        set_vec(4, 16'd0,  '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                0, 1, 1'b0, 1'b0, 16'h0, 16'h0, 16'd0, 16'd0, 3);
        set_vec(5, 16'd3,  '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'hF000, 16'h2000, 16'h0401, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                1, 2, 1'b1, 1'b1, 16'h1000, 16'h0400, 16'd2, 16'd3, 9);
        set_vec(6, 16'd18, '{16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18},
                '{16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10},
                0, 4, 1'b1, 1'b0, 16'h0070, 16'h0010, 16'd7, 16'd8, 17);
        set_vec(7, 16'd9,  '{16'd5, 16'd0, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                '{16'h0020, 16'h0001, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                0, 1, 1'b0, 1'b0, 16'h0, 16'h0, 16'd0, 16'd1, 5);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({cyc, stb, we, busy_o, done_o, err_o, found_o, museirq_o}), 32'd0);
        chk("rst_mbase", 32'(mbase_o), 32'd0);
        chk("rst_devcnt", 32'(devcnt_o), 32'd0);
        chk("rst_info", 32'({socver_o, socid_o}), 32'd0);
        rst = 1'b0;

        // Stray ack with no transfer outstanding
        @(negedge clk); force_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_stray_ack", 32'({cyc, busy_o, done_o, devcnt_o}), 32'd0);
        force_ack = 1'b0;

        for (int i = 0; i < 8; i++) begin
            t_id = vt[i].ids; t_sz = vt[i].szs;
            bsy_cycles = vt[i].bsy_n; ack_delay = vt[i].ack_n;
            e = '{err: 1'b0, found: vt[i].found, museirq: vt[i].museirq, mbase: vt[i].mbase,
                  mmapsz: vt[i].mmapsz, midx: vt[i].midx, devcnt: vt[i].devcnt,
                  socver: EXP_V, socid: EXP_S};
            run_scan(vt[i].tgt, e, vt[i].xfers + PRE - 1, vt[i].bsy_n + 1, i == 1, ncyc);
        end

        // Responder never acknowledges
        no_ack = 1'b1; bsy_cycles = 0;
        e = '{err: 1'b1, found: 1'b0, museirq: 1'b0, mbase: '0, mmapsz: '0, midx: '0,
              devcnt: '0, socver: '0, socid: '0};
        run_scan(16'd1, e, 1, 1, 1'b0, ncyc);
        chk("timeout_cyc_len_ok", 32'(ncyc >= TMO && ncyc <= TMO + 1), 32'd1);
        no_ack = 1'b0;

        // Reset while reading the size word of entry 2
        t_id = vt[0].ids; t_sz = vt[0].szs; bsy_cycles = 0; ack_delay = 1;
        @(negedge clk); tgtid = 16'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk);
            if (cyc && !we && addr == AW'(DTA + 5)) hit = 1'b1;
        end
        chk("rdsz2_reached", 32'(hit), 32'd1);
        chk("found_before_rst", 32'(found_o), 32'd1);
        chk("devcnt_before_rst", 32'(devcnt_o), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ctrl", 32'({cyc, stb, busy_o, done_o, err_o, found_o}), 32'd0);
        chk("midrst_devcnt", 32'(devcnt_o), 32'd0);
        chk("midrst_mmapsz", 32'(mmapsz_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e = '{err: 1'b0, found: 1'b1, museirq: 1'b0, mbase: 16'h0C00, mmapsz: 16'h1000,
              midx: 16'd2, devcnt: 16'd3, socver: EXP_V, socid: EXP_S};
        run_scan(16'd1, e, 9 + PRE - 1, 1, 1'b0, ncyc);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
